// File: rtl/rv32_pkg.sv
// Shared RV32I core definitions.
//   - arb_state_e : memory-port arbiter FSM state (IDLE / REQ / WAIT)
//   - owner_e     : which requester owns the transaction in flight
//   - XLEN_DEFAULT: default address/data width
package rv32_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

endpackage

// File: rtl/arb_watchdog.sv
// Transaction watchdog: counts enabled cycles and pulses 'expired' in the
// TIMEOUT-th consecutive enabled cycle. TIMEOUT = 0 disables it entirely.
//   clk, rst : clock, asynchronous active-low reset
//   clear    : return the count to zero (has priority over enable)
//   enable   : count this cycle
//   expired  : high during the cycle in which the TIMEOUT-th enabled cycle runs
module arb_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (TIMEOUT == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

            // count holds the number of enabled cycles already completed,
            // so expiry is seen while the TIMEOUT-th cycle is in progress.
            logic [CW-1:0] count;

            assign expired = enable && (count == CW'(TIMEOUT - 1));

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    count <= '0;
                end else if (clear) begin
                    count <= '0;
                end else if (enable) begin
                    count <= expired ? '0 : count + CW'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (if_*) and data access
// (dm_*). One transaction at a time: IDLE (arbitrate + grant) -> REQ
// (mem_req until mem_ready) -> WAIT (until mem_rvalid) -> IDLE.
//   clk, rst        : clock, asynchronous active-low reset
//   if_req/if_addr  : fetch request, held until if_gnt
//   if_flush        : drop the response of the current/just-granted fetch
//   if_gnt          : fetch accepted (combinational pulse in IDLE)
//   if_rvalid/rdata/err : fetch response pulse, err = watchdog abort
//   dm_req/we/be/addr/wdata : data request, held until dm_gnt
//   dm_gnt          : data accepted
//   dm_rvalid/rdata/err : load data or store ack, err = watchdog abort
//   mem_req/we/be/addr/wdata : request to memory, stable while mem_req
//   mem_ready       : memory accepts the request this cycle
//   mem_rvalid/rdata: memory response (also store ack)
//   busy            : a transaction is in progress (state != IDLE)
module mem_port_arbiter
    import rv32_pkg::*;
#(
    parameter int XLEN         = XLEN_DEFAULT,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    input  logic            if_flush,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [XLEN-1:0] if_rdata,
    output logic            if_err,
    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [3:0]      dm_be,
    input  logic [XLEN-1:0] dm_addr,
    input  logic [XLEN-1:0] dm_wdata,
    output logic            dm_gnt,
    output logic            dm_rvalid,
    output logic [XLEN-1:0] dm_rdata,
    output logic            dm_err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ready,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            busy
);

    localparam int            LW       = $clog2(STARVE_LIMIT + 1);
    localparam logic [LW-1:0] LOSS_MAX = LW'(STARVE_LIMIT);

    arb_state_e    state;
    owner_e        owner;
    logic          kill;
    logic [LW-1:0] loss_cnt;

    logic in_txn;
    logic starved;
    logic if_wins;
    logic dm_wins;
    logic grant_if;
    logic grant_dm;
    logic kill_now;
    logic killed;
    logic done_ok;
    logic abort;
    logic wd_expired;

    assign in_txn  = (state != ST_IDLE);
    assign busy    = in_txn;

    // Data normally wins; after STARVE_LIMIT contested losses fetch wins.
    assign starved = (loss_cnt == LOSS_MAX);
    assign if_wins = if_req && (!dm_req || starved);
    assign dm_wins = dm_req && !if_wins;

    // The winner is held off for one cycle while its own response pulses, so
    // a requester never sees gnt and rvalid together. The other requester is
    // not promoted in that cycle, which keeps the starvation count honest.
    // NOTE: gnt is combinational from the requests, so it is masked with rst
    // to keep every output low while reset is asserted.
    assign grant_if = rst && (state == ST_IDLE) && if_wins && !if_rvalid;
    assign grant_dm = rst && (state == ST_IDLE) && dm_wins && !dm_rvalid;
    assign if_gnt   = grant_if;
    assign dm_gnt   = grant_dm;

    // A flush landing in the completion cycle still suppresses that response.
    assign kill_now = in_txn && (owner == OWN_IF) && if_flush;
    assign killed   = kill || kill_now;

    // A response arriving in the expiry cycle takes precedence over the abort.
    assign done_ok  = (state == ST_WAIT) && mem_rvalid;
    assign abort    = in_txn && wd_expired && !done_ok;

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (!in_txn),
        .enable  (in_txn),
        .expired (wd_expired)
    );

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            owner     <= OWN_IF;
            kill      <= 1'b0;
            loss_cnt  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'h0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            if_err    <= 1'b0;
            dm_rvalid <= 1'b0;
            dm_rdata  <= '0;
            dm_err    <= 1'b0;
        end else begin
            // Response strobes are single-cycle pulses.
            if_rvalid <= 1'b0;
            if_err    <= 1'b0;
            dm_rvalid <= 1'b0;
            dm_err    <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (grant_dm) begin
                        owner     <= OWN_DM;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_be    <= dm_be;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        state     <= ST_REQ;
                        if (if_req && !starved) begin
                            loss_cnt <= loss_cnt + LW'(1);
                        end
                    end else if (grant_if) begin
                        owner     <= OWN_IF;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_be    <= 4'hF;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        state     <= ST_REQ;
                        loss_cnt  <= '0;
                        kill      <= if_flush;
                    end
                end

                ST_REQ, ST_WAIT: begin
                    if (kill_now) begin
                        kill <= 1'b1;
                    end
                    if (done_ok || abort) begin
                        state   <= ST_IDLE;
                        mem_req <= 1'b0;
                        kill    <= 1'b0;
                        if (owner == OWN_DM) begin
                            dm_rvalid <= 1'b1;
                            dm_err    <= abort;
                            dm_rdata  <= done_ok ? mem_rdata : '0;
                        end else if (!killed) begin
                            if_rvalid <= 1'b1;
                            if_err    <= abort;
                            if_rdata  <= done_ok ? mem_rdata : '0;
                        end
                    end else if ((state == ST_REQ) && mem_ready) begin
                        mem_req <= 1'b0;
                        state   <= ST_WAIT;
                    end
                end

                default: begin
                    state   <= ST_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
